// File: rtl/key_event_pkg.sv
// Shared constants for the key event classifier: one-hot FSM encoding,
// the millisecond tick rate and counter sizing helpers.
package key_event_pkg;

  localparam int TICK_HZ = 1000;

  localparam logic [3:0] ST_LOCK  = 4'b0001;
  localparam logic [3:0] ST_IDLE  = 4'b0010;
  localparam logic [3:0] ST_PRESS = 4'b0100;
  localparam logic [3:0] ST_LONG  = 4'b1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_event_ms_tick.sv
// Prescaler: counts 0..DIV-1 and flags the wrap cycle; clr restarts the
// count so the first tick lands exactly DIV clocks after clr is released.
module ms_tick
  import key_event_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/key_event.sv
// Classifies a debounced key into short, long and (with KEY_EVENT_REPEAT_EN)
// auto-repeat pulses; all outputs are registered one-cycle events.
//
// state | meaning
// LOCK  | after reset, wait for the key to be released before arming
// IDLE  | armed, key released, counters held at zero
// PRESS | key down, timing toward the long threshold
// LONG  | long press reported, optionally repeating until release
module key_event
  import key_event_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  output logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int            DIV       = CLK_FREQ / TICK_HZ;
  localparam int            MW        = cnt_width(max_int(LONG_MS, REPEAT_MS));
  localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
  localparam logic [MW-1:0] MS_ONE    = MW'(1);

  logic [3:0]    r_state;
  logic [MW-1:0] r_ms;
  logic          r_pressed;
  logic          r_short;
  logic          r_long;

  logic [3:0]    w_next;
  logic          w_tick;
  logic          w_clr;
  logic          w_short;
  logic          w_long;
  logic          w_ms_restart;

  ms_tick #(
    .DIV (DIV)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [MW-1:0] REP_LAST = MW'(REPEAT_MS - 1);
  logic r_repeat;
  logic w_repeat;
`endif

  always_comb begin
    w_next       = r_state;
    w_clr        = 1'b1;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_ms_restart = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
    w_repeat     = 1'b0;
`endif
    case (r_state)
      ST_LOCK: begin
        if (!key_level) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (key_level) w_next = ST_PRESS;
      end
      ST_PRESS: begin
        // Threshold beats a coincident release: long is reported, short is not.
        if (w_tick && (r_ms == LONG_LAST)) begin
          w_long = 1'b1;
          w_next = key_level ? ST_LONG : ST_IDLE;
        end else if (!key_level) begin
          w_short = 1'b1;
          w_next  = ST_IDLE;
        end else begin
          w_clr = 1'b0;
        end
      end
      ST_LONG: begin
        if (!key_level) begin
          w_next = ST_IDLE;
        end else begin
`ifdef KEY_EVENT_REPEAT_EN
          w_clr = 1'b0;
          if (w_tick && (r_ms == REP_LAST)) begin
            w_repeat     = 1'b1;
            w_ms_restart = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_next = ST_LOCK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr || w_ms_restart) begin
      r_ms <= '0;
    end else if (w_tick) begin
      r_ms <= r_ms + MS_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LOCK;
      r_pressed <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pressed <= (w_next == ST_PRESS) || (w_next == ST_LONG);
      r_short   <= w_short;
      r_long    <= w_long;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= w_repeat;
    end
  end
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign pressed     = r_pressed;
  assign short_pulse = r_short;
  assign long_pulse  = r_long;

endmodule

// File: tb/tb_key_event.sv
// Randomized scoreboard bench for key_event; expected events are derived
// from press durations, checked by an independent per-edge monitor.
module tb_key_event;

  localparam int CLK_FREQ  = 10000;
  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int DIV       = CLK_FREQ / 1000;
  localparam int LD        = LONG_MS * DIV;
  localparam int RD        = REPEAT_MS * DIV;
  localparam int K_SHORT   = 1;
  localparam int K_LONG    = 2;
  localparam int K_REP     = 3;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    int edge_n;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_level = 1'b0;
  logic pressed, short_pulse, long_pulse, repeat_pulse;

  ev_t eq[$];
  bit  pq[$];
  int  cyc   = 0;
  int  nxt   = 2;
  int  total = 0;
  int  bad   = 0;
  bit  done  = 1'b0;

  key_event #(
    .CLK_FREQ  (CLK_FREQ),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_level    (key_level),
    .pressed      (pressed),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Drives the inputs sampled by edge nxt and records the pressed level expected after it.
  task automatic drive(input bit k, input bit r, input bit p);
    @(negedge clk);
    key_level = k;
    rst       = r;
    pq.push_back(p);
    nxt++;
  endtask

  task automatic push_ev(input int e, input int k);
    ev_t x;
    x.edge_n = e;
    x.kind   = k;
    eq.push_back(x);
  endtask

  // Key high for h sampled edges, then low for g edges.
  task automatic do_press(input int h, input int g);
    int e0;
    e0 = nxt;
    if (h < LD) begin
      push_ev(e0 + h, K_SHORT);
    end else begin
      push_ev(e0 + LD, K_LONG);
      if (REP) for (int t = e0 + LD + RD; t < e0 + h; t += RD) push_ev(t, K_REP);
    end
    repeat (h) drive(1'b1, 1'b0, 1'b1);
    repeat (g) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Key held; reset hits hb edges into the press; key stays held ha more edges.
  task automatic do_reset_press(input int hb, input int ha, input int g);
    int e0, r;
    e0 = nxt;
    r  = e0 + hb;
    if (e0 + LD < r) begin
      push_ev(e0 + LD, K_LONG);
      if (REP) for (int t = e0 + LD + RD; t < r; t += RD) push_ev(t, K_REP);
    end
    repeat (hb) drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    repeat (ha) drive(1'b1, 1'b0, 1'b0);
    repeat (g) drive(1'b0, 1'b0, 1'b0);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_SHORT: return "short";
      K_LONG:  return "long";
      K_REP:   return "repeat";
      default: return "none";
    endcase
  endfunction

  bit  m_p;
  int  m_nk, m_kind;
  ev_t m_x;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!done && pq.size() > 0) begin
      m_p = pq.pop_front();
      total++;
      if (pressed !== m_p) begin
        bad++;
        $display("FAIL pressed edge=%0d got=%b want=%b", cyc, pressed, m_p);
      end
      m_nk = int'(short_pulse === 1'b1) + int'(long_pulse === 1'b1) + int'(repeat_pulse === 1'b1);
      total++;
      if (m_nk > 1) begin
        bad++;
        $display("FAIL onehot edge=%0d got=%b%b%b want at most one", cyc, short_pulse, long_pulse, repeat_pulse);
      end
      if (m_nk > 0) begin
        m_kind = (short_pulse === 1'b1) ? K_SHORT : (long_pulse === 1'b1) ? K_LONG : K_REP;
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL unexpected edge=%0d got=%s want=none", cyc, kname(m_kind));
        end else begin
          m_x = eq.pop_front();
          if (m_x.edge_n != cyc || m_x.kind != m_kind) begin
            bad++;
            $display("FAIL event got=%s@%0d want=%s@%0d", kname(m_kind), cyc, kname(m_x.kind), m_x.edge_n);
          end
        end
      end else begin
        while (eq.size() > 0 && eq[0].edge_n <= cyc) begin
          m_x = eq.pop_front();
          total++;
          bad++;
          $display("FAIL missed edge=%0d got=none want=%s@%0d", cyc, kname(m_x.kind), m_x.edge_n);
        end
      end
    end
  end

  initial begin
    int sel, h;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    do_press(20, 3);
    do_press(100, 3);
    do_press(LD, 3);
    do_reset_press(30, 49, 2);
    do_press(10, 3);
    do_press(1, 3);
    do_press(LD - 1, 2);
    do_press(LD + 1, 2);
    do_reset_press(LD + RD + 3, 5, 1);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do_reset_press($urandom_range(1, 130), $urandom_range(0, 10), $urandom_range(1, 4));
      end else begin
        if (sel < 3) h = LD - 1 + $urandom_range(0, 2);
        else         h = $urandom_range(1, 140);
        do_press(h, $urandom_range(1, 6));
      end
    end
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    done = 1'b1;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d pending want=0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning press duration in ms that makes a long press (>=1).
REQ-003 SHALL have parameter REPEAT_MS, default 200, meaning auto-repeat period in ms while long-held (>=1).
REQ-004 SHALL have port clk  input  1  single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port key_level  input  1  debounced key level from the key filter, 1 = pressed.
REQ-007 SHALL have port pressed  output  1  registered, 1 while the FSM is in PRESS or LONG.
REQ-008 SHALL have port short_pulse  output  1  registered, one-cycle pulse on release of a short press.
REQ-009 SHALL have port long_pulse  output  1  registered, one-cycle pulse when a hold reaches LONG_MS.
REQ-010 SHALL have port repeat_pulse  output  1  registered, one-cycle pulse every REPEAT_MS in LONG.

Function
REQ-011 SHALL derive DIV = CLK_FREQ/1000 clocks per ms tick, with a ms counter of width clog2(max(LONG_MS,REPEAT_MS)+1).
REQ-012 SHALL implement states LOCK, IDLE, PRESS, LONG.
REQ-013 LOCK SHALL go to IDLE on the first edge that samples key_level=0, with no event output.
REQ-014 IDLE SHALL go to PRESS on the edge that samples key_level=1, clearing the prescaler and ms counter on that edge.
REQ-015 In PRESS, the prescaler SHALL count 0..DIV-1 and wrap, and the ms counter SHALL increment on each wrap.
REQ-016 PRESS SHALL go to LONG and assert long_pulse for one cycle exactly LONG_MS*DIV edges after the edge that entered PRESS.
REQ-017 PRESS SHALL go to IDLE and assert short_pulse for one cycle on the edge that samples key_level=0 before the long threshold.
REQ-018 If release and the long threshold coincide on the same edge, the block SHALL emit long_pulse only (no short_pulse) and go to IDLE.
REQ-019 LONG SHALL go to IDLE on release with no pulse, and the prescaler and ms counter SHALL be cleared on entry to LONG.
REQ-020 At most one of short_pulse, long_pulse, repeat_pulse SHALL be high in any cycle, and every pulse SHALL be exactly one cycle wide.
REQ-021 The counters SHALL hold at zero in LOCK and IDLE, and no counter SHALL ever overflow or wrap past its terminal value.

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state=LOCK, all outputs 0 and all counters 0, regardless of state or key_level.
REQ-023 Reset mid-press SHALL discard the press, and a key held through reset SHALL produce no event until released and pressed again.

Configuration
REQ-024 With macro KEY_EVENT_REPEAT_EN defined, LONG SHALL assert repeat_pulse every REPEAT_MS*DIV edges, the first at REPEAT_MS*DIV edges after entering LONG, until release.
REQ-025 Without KEY_EVENT_REPEAT_EN, the repeat_pulse port SHALL remain present and tied to 0, and no repeat counter logic SHALL be generated.

Structure
REQ-026 Package key_event_pkg SHALL hold the state encoding constants (one-hot, 4 bits) and TICK_HZ=1000.
REQ-027 The prescaler SHALL be a sub-module ms_tick (ports clk, rst, clr; parameter DIV; output tick, one cycle per DIV clocks since clr).
REQ-028 key_event SHALL contain the FSM, the ms counter, and the output registers.

Verification (CLK_FREQ=10000 -> DIV=10, LONG_MS=5, REPEAT_MS=2; "entry" = edge entering PRESS)
REQ-029 Hold key 20 cycles then release -> short_pulse high for exactly 1 cycle at release; long_pulse never asserted; pressed high for 20 cycles.
REQ-030 Hold key 100 cycles -> long_pulse at entry+50; no short_pulse on release; pressed high throughout.
REQ-031 With KEY_EVENT_REPEAT_EN, hold 100 cycles -> repeat_pulse at entry+70 and entry+90; without the macro -> repeat_pulse constantly 0.
REQ-032 Release sampled exactly at entry+50 -> long_pulse only, with zero short_pulse.
REQ-033 Assert rst for 1 cycle at entry+30 with the key held to cycle 80 -> no pulses, pressed=0; the next press/release of 10 cycles -> one short_pulse.
REQ-034 Single-cycle key_level high -> PRESS for one cycle, then one short_pulse.
